// File: rtl/axi4_lite_mem_bridge_pkg.sv
// Shared types and helpers for the AXI4-Lite to SRAM bridge.
package axi4_lite_mem_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    // Pointer/counter width that never collapses to zero bits.
    function automatic int clog2s(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when addr[addr_w-1:lsb] is all zero; an empty range means every address decodes.
    function automatic logic in_range(input logic [63:0] addr, input int addr_w, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++)
            if (i >= lsb && i < addr_w && addr[i])
                ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/axi4_lite_mem_bridge_if.sv
// AXI4-Lite slave-side channel bundle for the memory bridge.
interface axi4_lite_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  awvalid, awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid, wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid, bready;
    logic [1:0]            bresp;
    logic                  arvalid, arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid, rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_mem_bridge_sync_fifo.sv
// First-word-fall-through FIFO; BYPASS lets a push reach the head in the same cycle when empty.
module sync_fifo
    import axi4_lite_mem_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b0,
    localparam int CW    = clog2s(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = clog2s(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             none, thru, wr, rd;

    assign none  = (count == '0);
    assign thru  = BYPASS & none & push & pop;
    assign full  = (count == CW'(DEPTH));
    assign empty = none & ~(BYPASS & push);
    assign rdata = (BYPASS && none) ? wdata : mem[rptr];
    // A push into a full FIFO is legal only alongside a pop that frees the head slot.
    assign wr    = push & ~thru & (~full | pop);
    assign rd    = pop & ~none;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (rd) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[wptr] <= wdata;

endmodule

// File: rtl/axi4_lite_mem_bridge.sv
// AXI4-Lite slave to dual-port SRAM bridge with B queue and credit-limited R return FIFO.
// Define AXI4_LITE_MEM_BRIDGE_ERR_CNT_EN to add the saturating SLVERR counter output err_cnt.
module axi4_lite_mem_bridge
    import axi4_lite_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int RD_LATENCY = 1,
    parameter int B_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4_lite_mem_bridge_if.slave s,
    output logic                  mem_wen,
    output logic [MEM_ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_ren,
    output logic [MEM_ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef AXI4_LITE_MEM_BRIDGE_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);
    localparam int STRB_W = DATA_W / 8;
    localparam int ALIGN  = $clog2(STRB_W);
    localparam int HI_LSB = ALIGN + MEM_ADDR_W;
    localparam int BCW    = clog2s(B_DEPTH + 1);
    localparam int CCW    = clog2s(RD_LATENCY + 2);
    localparam int RDEP   = RD_LATENCY + 1;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_dw
        $error("DATA_W must be 32 or 64");
    end
    if (ADDR_W < HI_LSB) begin : g_bad_aw
        $error("ADDR_W too small for MEM_ADDR_W");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("RD_LATENCY must be 1..4");
    end
    if (B_DEPTH < 2 || (B_DEPTH & (B_DEPTH - 1)) != 0) begin : g_bad_bd
        $error("B_DEPTH must be a power of 2, at least 2");
    end

    // ---------------- write path ----------------
    logic              aw_held, w_held, aw_hs, w_hs, aw_avail, w_avail, fire, aw_ok;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [1:0]        b_wdata, b_head;
    logic              b_full, b_empty;
    logic [BCW-1:0]    b_count;

    assign s.awready = ~aw_held & ~rst;
    assign s.wready  = ~w_held & ~rst;
    assign aw_hs     = s.awvalid & s.awready;
    assign w_hs      = s.wvalid & s.wready;
    assign aw_avail  = aw_held | aw_hs;
    assign w_avail   = w_held | w_hs;
    // Registered count only: a same-cycle B pop does not open a slot.
    assign fire      = aw_avail & w_avail & (b_count < BCW'(B_DEPTH)) & ~rst;
    assign aw_addr   = aw_held ? aw_addr_q : s.awaddr;
    assign aw_ok     = in_range(64'(aw_addr), ADDR_W, HI_LSB);
    assign b_wdata   = aw_ok ? OKAY : SLVERR;

    assign mem_wen   = fire & aw_ok;
    assign mem_waddr = aw_addr[ALIGN +: MEM_ADDR_W];
    assign mem_wdata = w_held ? w_data_q : s.wdata;
    assign mem_wstrb = w_held ? w_strb_q : s.wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (fire)       aw_held <= 1'b0;
            else if (aw_hs) aw_held <= 1'b1;
            if (fire)       w_held  <= 1'b0;
            else if (w_hs)  w_held  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs && !fire) aw_addr_q <= s.awaddr;
        if (w_hs && !fire) begin
            w_data_q <= s.wdata;
            w_strb_q <= s.wstrb;
        end
    end

    sync_fifo #(.WIDTH(2), .DEPTH(B_DEPTH), .BYPASS(1'b0)) u_bq (
        .clk, .rst, .push(fire), .wdata(b_wdata), .pop(s.bvalid & s.bready),
        .rdata(b_head), .full(b_full), .empty(b_empty), .count(b_count)
    );

    assign s.bvalid = ~b_empty & ~rst;
    assign s.bresp  = s.bvalid ? b_head : OKAY;

    // ---------------- read path ----------------
    logic                   ar_hs, r_hs, ar_ok, r_push, r_full, r_empty;
    logic [CCW-1:0]         credit;
    logic [RD_LATENCY:1]    vld_pipe, err_pipe;
    logic [DATA_W+1:0]      r_wdata, r_head;
    logic [clog2s(RDEP+1)-1:0] r_count;

    assign s.arready = (credit < CCW'(RD_LATENCY + 1)) & ~rst;
    assign ar_hs     = s.arvalid & s.arready;
    assign r_hs      = s.rvalid & s.rready;
    assign ar_ok     = in_range(64'(s.araddr), ADDR_W, HI_LSB);
    assign mem_ren   = ar_hs & ar_ok;
    assign mem_raddr = s.araddr[ALIGN +: MEM_ADDR_W];

    always_ff @(posedge clk) begin
        if (rst)                credit <= '0;
        else if (ar_hs && !r_hs) credit <= credit + 1'b1;
        else if (!ar_hs && r_hs) credit <= credit - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            err_pipe <= '0;
        end else begin
            vld_pipe[1] <= ar_hs;
            err_pipe[1] <= ~ar_ok;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
            end
        end
    end

    assign r_push  = vld_pipe[RD_LATENCY];
    assign r_wdata = err_pipe[RD_LATENCY] ? {DATA_W'(0), SLVERR} : {mem_rdata, OKAY};

    // Bypass lets memory data reach R in its arrival cycle, so credit sustains 1 read/cycle.
    sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(RDEP), .BYPASS(1'b1)) u_rq (
        .clk, .rst, .push(r_push), .wdata(r_wdata), .pop(r_hs),
        .rdata(r_head), .full(r_full), .empty(r_empty), .count(r_count)
    );

    assign s.rvalid = ~r_empty & ~rst;
    assign s.rdata  = s.rvalid ? r_head[DATA_W+1:2] : '0;
    assign s.rresp  = s.rvalid ? r_head[1:0] : OKAY;

    logic unused_ok;
    assign unused_ok = &{1'b0, b_full, r_full, r_count};

`ifdef AXI4_LITE_MEM_BRIDGE_ERR_CNT_EN
    logic [1:0] err_inc;
    assign err_inc = 2'(fire & ~aw_ok) + 2'(r_push & err_pipe[RD_LATENCY]);

    always_ff @(posedge clk) begin
        if (rst)                                    err_cnt <= '0;
        else if (err_cnt > 16'hFFFF - 16'(err_inc)) err_cnt <= 16'hFFFF;
        else                                        err_cnt <= err_cnt + 16'(err_inc);
    end
`endif

endmodule

// File: tb/tb_axi4_lite_mem_bridge.sv
// Directed bench for axi4_lite_mem_bridge (RD_LATENCY=2, B_DEPTH=4) with a behavioural SRAM.
module tb_axi4_lite_mem_bridge;
    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wen, mem_ren;
    logic [9:0]  mem_waddr, mem_raddr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef AXI4_LITE_MEM_BRIDGE_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    axi4_lite_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi4_lite_mem_bridge #(
        .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .RD_LATENCY(RDL), .B_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .s(bus),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
`ifdef AXI4_LITE_MEM_BRIDGE_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: unwritten word w reads as 0xA5000000 | w.
    logic [31:0]   ram [1024];
    logic [1023:0] wmask = '0;
    logic [31:0]   rd_pipe [1:RDL];
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b])
                    ram[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            for (int b = 0; b < 4; b++)
                if (!mem_wstrb[b] && !wmask[mem_waddr])
                    ram[mem_waddr][8*b +: 8] <= 8'(({22'h0, mem_waddr} | 32'hA500_0000) >> (8*b));
            wmask[mem_waddr] <= 1'b1;
        end
        rd_pipe[1] <= !mem_ren ? 32'h0 :
                      wmask[mem_raddr] ? ram[mem_raddr] : (32'hA500_0000 | {22'h0, mem_raddr});
        for (int k = 2; k <= RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[RDL];

    // Event monitor, sampled mid-cycle.
    int          wen_cnt = 0, ren_cnt = 0;
    logic [9:0]  wa_q [$];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];
    always @(negedge clk) begin
        if (mem_wen) begin wen_cnt++; wa_q.push_back(mem_waddr); end
        if (mem_ren) ren_cnt++;
        if (bus.bvalid && bus.bready) b_q.push_back(bus.bresp);
        if (bus.rvalid && bus.rready) r_q.push_back({bus.rresp, bus.rdata});
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
        #1;
        n = 0;
        while (!bus.arready && n < 20) begin tick; n++; end
        chk({tag, "_ren"}, 64'(mem_ren), 64'(er == 2'b00));
        tick;
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin tick; n++; end
        chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(bus.rdata), 64'(ed));
        chk({tag, "_rresp"}, 64'(bus.rresp), 64'(er));
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bbase, rbase, renb, i, n, acc;
        logic hs;

        // Reset with live valids: nothing may leak out.
        rst = 1'b1;
        bus.awvalid = 1'b1; bus.awaddr = 32'h0; bus.wvalid = 1'b1; bus.wdata = '1; bus.wstrb = 4'hF;
        bus.bready = 1'b0; bus.arvalid = 1'b1; bus.araddr = 32'h0; bus.rready = 1'b0;
        tick; tick;
        chk("rst_awready", 64'(bus.awready), 0);
        chk("rst_arready", 64'(bus.arready), 0);
        chk("rst_mem_wen", 64'(mem_wen), 0);
        chk("rst_mem_ren", 64'(mem_ren), 0);
        chk("rst_valids", 64'({bus.bvalid, bus.rvalid}), 0);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'b111);
        chk("post_rst_resp_data", 64'({bus.bresp, bus.rresp, bus.rdata}), 0);
        chk("post_rst_wen_cnt", 64'(wen_cnt), 0);

        // AW alone, W three cycles later.
        base = wen_cnt;
        bus.awvalid = 1'b1; bus.awaddr = 32'h10;
        tick;
        bus.awvalid = 1'b0;
        chk("t1_aw_held", 64'(bus.awready), 0);
        tick; tick;
        chk("t1_no_early_write", 64'(wen_cnt - base), 0);
        bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'b0101;
        #1;
        chk("t1_wen", 64'(mem_wen), 1);
        chk("t1_waddr", 64'(mem_waddr), 4);
        chk("t1_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("t1_wstrb", 64'(mem_wstrb), 4'b0101);
        tick;
        bus.wvalid = 1'b0;
        chk("t1_bvalid", 64'(bus.bvalid), 1);
        chk("t1_bresp", 64'(bus.bresp), 0);
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
        chk("t1_b_popped", 64'(bus.bvalid), 0);
        chk("t1_wen_total", 64'(wen_cnt - base), 1);

        // Six writes against a stalled B channel.
        base = wen_cnt; bbase = b_q.size(); i = 0;
        for (int c = 0; c < 8; c++) begin
            bus.awvalid = (i < 6); bus.wvalid = (i < 6);
            bus.awaddr = 32'h20 + 32'(4 * i); bus.wdata = 32'h100 + 32'(i); bus.wstrb = 4'hF;
            #1 hs = bus.awvalid & bus.awready & bus.wready;
            tick;
            if (hs) i++;
        end
        chk("t2_wen_when_full", 64'(wen_cnt - base), 4);
        chk("t2_accepted", 64'(i), 5);
        chk("t2_stall", 64'({bus.awready, bus.wready}), 0);
        bus.bready = 1'b1; n = 0;
        while ((i < 6 || bus.bvalid) && n < 30) begin
            bus.awvalid = (i < 6); bus.wvalid = (i < 6);
            bus.awaddr = 32'h20 + 32'(4 * i); bus.wdata = 32'h100 + 32'(i);
            #1 hs = bus.awvalid & bus.awready & bus.wready;
            tick;
            if (hs) i++;
            n++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        chk("t2_wen_total", 64'(wen_cnt - base), 6);
        chk("t2_b_count", 64'(b_q.size() - bbase), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_bresp%0d", k), 64'(b_q[bbase + k]), 0);
            chk($sformatf("t2_waddr%0d", k), 64'(wa_q[wa_q.size() - 6 + k]), 64'(8 + k));
        end

        // Out-of-range write and read.
        base = wen_cnt;
        bus.awvalid = 1'b1; bus.awaddr = 32'h1000; bus.wvalid = 1'b1; bus.wdata = 32'h1234_5678;
        #1 chk("t3_no_wen", 64'(mem_wen), 0);
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("t3_bresp", 64'({bus.bvalid, bus.bresp}), 64'b110);
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
        chk("t3_wen_total", 64'(wen_cnt - base), 0);
        rd1("t3_rd", 32'h1000, 32'h0, 2'b10);
`ifdef AXI4_LITE_MEM_BRIDGE_ERR_CNT_EN
        chk("t3_err_cnt", 64'(err_cnt), 2);
`endif

        // Byte strobes only touched bytes 0 and 2 of word 4.
        rd1("t4_strb", 32'h10, 32'hA5AD_00EF, 2'b00);

        // Eight back-to-back reads with rready high.
        rbase = r_q.size(); renb = ren_cnt; acc = 0;
        bus.rready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.arvalid = 1'b1; bus.araddr = 32'h40 + 32'(4 * k);
            #1;
            if (bus.arready) acc++;
            if (k == 1) chk("t4_rvalid_early", 64'(bus.rvalid), 0);
            if (k == 2) chk("t4_rvalid_lat", 64'(bus.rvalid), 1);
            tick;
        end
        bus.arvalid = 1'b0;
        n = 0;
        while (r_q.size() - rbase < 8 && n < 20) begin tick; n++; end
        chk("t4_accepted", 64'(acc), 8);
        chk("t4_ren", 64'(ren_cnt - renb), 8);
        chk("t4_r_count", 64'(r_q.size() - rbase), 8);
        for (int k = 0; k < 8 && rbase + k < r_q.size(); k++)
            chk($sformatf("t4_r%0d", k), 64'(r_q[rbase + k]), 64'({2'b00, 32'hA500_0010 + 32'(k)}));

        // Credit stall with rready low.
        bus.rready = 1'b0; acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.arvalid = 1'b1; bus.araddr = 32'h80 + 32'(4 * acc);
            #1 if (bus.arready) acc++;
            tick;
        end
        chk("t5_accepted", 64'(acc), 3);
        chk("t5_arready_stall", 64'(bus.arready), 0);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        rbase = r_q.size(); n = 0;
        while (r_q.size() - rbase < 3 && n < 20) begin tick; n++; end
        tick;
        chk("t5_arready_back", 64'(bus.arready), 1);
        chk("t5_r_count", 64'(r_q.size() - rbase), 3);
        for (int k = 0; k < 3 && rbase + k < r_q.size(); k++)
            chk($sformatf("t5_r%0d", k), 64'(r_q[rbase + k]), 64'({2'b00, 32'hA500_0020 + 32'(k)}));

        // Reset with queued B responses and a read in flight.
        bus.rready = 1'b0; bus.bready = 1'b0;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = 32'h200;
        tick;
        bus.awaddr = 32'h204;
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 32'h2000;
        chk("t6_b_queued", 64'(bus.bvalid), 1);
        tick;
        bus.arvalid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("t6_valids_cleared", 64'({bus.bvalid, bus.rvalid}), 0);
        chk("t6_arready", 64'(bus.arready), 1);
`ifdef AXI4_LITE_MEM_BRIDGE_ERR_CNT_EN
        chk("t6_err_cnt", 64'(err_cnt), 0);
`endif
        bbase = b_q.size(); rbase = r_q.size();
        bus.bready = 1'b1; bus.rready = 1'b1;
        repeat (6) tick;
        chk("t6_no_stale_b", 64'(b_q.size() - bbase), 0);
        chk("t6_no_stale_r", 64'(r_q.size() - rbase), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
